// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan sequencer and its index helper.
package scan_seq_pkg;

  localparam int unsigned IDX_W     = 3;
  localparam int unsigned NUM_LINES = 8;
  localparam logic [IDX_W-1:0] SEL_RESET = 3'b000;

  typedef enum logic {StIdle, StDwell} state_e;

  // Index of the lowest set bit; SEL_RESET when the mask is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_LINES-1:0] mask);
    lowest_set = SEL_RESET;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/scan_next_idx.sv
// Combinational lookup of the next enabled line above idx and the lowest enabled line.
module scan_next_idx
  import scan_seq_pkg::*;
(
  input  logic [NUM_LINES-1:0] mask_q,
  input  logic [IDX_W-1:0]     idx,
  output logic [IDX_W-1:0]     next_hi_idx,
  output logic                 has_hi,
  output logic [IDX_W-1:0]     lowest_idx
);

  always_comb begin
    has_hi      = 1'b0;
    next_hi_idx = idx;
    // Descending scan so the last hit is the nearest enabled line above idx.
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(idx))) begin
        has_hi      = 1'b1;
        next_hi_idx = IDX_W'(i);
      end
    end
  end

  assign lowest_idx = lowest_set(mask_q);

endmodule

// File: rtl/scan_sequencer.sv
// Walks the 3-bit decoder select across enabled lines with a programmable dwell.
// Optional pass counter output enabled by defining SCAN_SEQ_PASS_CNT_EN.
module scan_sequencer #(
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned NUM_LINES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_LINES-1:0] line_mask,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_c,
  output logic               valid,
  output logic               busy,
  output logic               wrap,
`ifdef SCAN_SEQ_PASS_CNT_EN
  output logic [7:0]         pass_cnt,
`endif
  output logic               done
);

  import scan_seq_pkg::*;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [NUM_LINES-1:0] mask_q, mask_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 wrap_q, wrap_d;
  logic                 done_q, done_d;

  logic [IDX_W-1:0]     next_hi_idx, lowest_idx;
  logic                 has_hi;
  logic                 accept;
  logic [DWELL_W-1:0]   reload, start_reload;

  scan_next_idx u_next_idx (
    .mask_q      (mask_q),
    .idx         (idx_q),
    .next_hi_idx (next_hi_idx),
    .has_hi      (has_hi),
    .lowest_idx  (lowest_idx)
  );

  // A dwell of zero behaves as one cycle per line.
  assign reload       = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  assign start_reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign accept       = (state_q == StIdle) && start && !stop && (|line_mask);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = StIdle;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StDwell;
            mask_d  = line_mask;
            dwell_d = dwell;
            idx_d   = lowest_set(line_mask);
            cnt_d   = start_reload;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        StDwell: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (has_hi) begin
            idx_d = next_hi_idx;
            cnt_d = reload;
          end else begin
            wrap_d = 1'b1;
            if (mode) begin
              idx_d = lowest_idx;
              cnt_d = reload;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
              valid_d = 1'b0;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= SEL_RESET;
      dwell_q <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign {sel_a, sel_b, sel_c} = idx_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

`ifdef SCAN_SEQ_PASS_CNT_EN
  logic [7:0] pass_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      pass_cnt_q <= '0;
    end else if (wrap_d && (pass_cnt_q != 8'hFF)) begin
      pass_cnt_q <= pass_cnt_q + 8'd1;
    end
  end

  assign pass_cnt = pass_cnt_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: expected select/wrap events are queued from a
// pass-level model and consumed by a negedge monitor.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [7:0] dwell, line_mask;
  logic       sel_a, sel_b, sel_c, valid, busy, wrap, done;
`ifdef SCAN_SEQ_PASS_CNT_EN
  logic [7:0] pass_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_sel_q[$];
  bit exp_done_q[$];

  always #5 clk = ~clk;

  scan_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .line_mask (line_mask),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .sel_c     (sel_c),
    .valid     (valid),
    .busy      (busy),
    .wrap      (wrap),
`ifdef SCAN_SEQ_PASS_CNT_EN
    .pass_cnt  (pass_cnt),
`endif
    .done      (done)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sel_now();
    return int'({sel_a, sel_b, sel_c});
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a live select or a wrap.
  always @(negedge clk) begin
    check("busy_eq_valid", int'(busy), int'(valid));
    if (valid) begin
      if (exp_sel_q.size() == 0) check("valid_without_expectation", int'(valid), 0);
      else check("sel", sel_now(), exp_sel_q.pop_front());
    end
    if (wrap) begin
      if (exp_done_q.size() == 0) begin
        check("wrap_without_expectation", int'(wrap), 0);
      end else begin
        bit e;
        e = exp_done_q.pop_front();
        check("done_with_wrap", int'(done), int'(e));
        if (e) check("valid_low_at_done", int'(valid), 0);
      end
    end else if (done) begin
      check("done_without_wrap", int'(done), 0);
    end
  end

  // kind: 0 = single pass runs to completion, 1 = stop after n cycles, 2 = rst after n cycles.
  task automatic run_scan(input logic [7:0] m, input logic [7:0] dw, input logic md,
                          input int n, input int kind, input bit poke);
    int en[$];
    int d, p, len, wraps, pj, last;
    for (int i = 0; i < 8; i++) if (m[i]) en.push_back(i);
    len   = en.size();
    d     = (dw == 0) ? 1 : int'(dw);
    p     = len * d;
    wraps = 0;
    for (int k = 0; k < n; k++) begin
      exp_sel_q.push_back(en[(k / d) % len]);
      if (k > 0 && (k % p) == 0) begin
        exp_done_q.push_back(1'b0);
        wraps++;
      end
    end
    if (kind == 0) begin
      exp_done_q.push_back(1'b1);
      wraps++;
    end
    last = en[((n - 1) / d) % len];
    pj   = (n >= 2) ? int'($urandom_range(1, n - 1)) : 0;

    @(posedge clk); #1;
    start = 1'b1; line_mask = m; dwell = dw; mode = md;
    @(posedge clk); #1;
    start = 1'b0; line_mask = 8'($urandom); dwell = 8'($urandom);
`ifdef SCAN_SEQ_PASS_CNT_EN
    @(negedge clk);
    check("pass_cnt_cleared_on_start", int'(pass_cnt), 0);
`endif
    for (int j = 1; j < n; j++) begin
      if (poke && j == pj) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      line_mask = 8'($urandom);
      dwell = 8'($urandom);
    end
    if (kind == 1) stop = 1'b1;
    if (kind == 2) rst = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("valid_after_end", int'(valid), 0);
    check("busy_after_end", int'(busy), 0);
    check("sel_after_end", sel_now(), (kind == 2) ? 0 : last);
    if (kind != 0) begin
      check("wrap_after_abort", int'(wrap), 0);
      check("done_after_abort", int'(done), 0);
    end
`ifdef SCAN_SEQ_PASS_CNT_EN
    check("pass_cnt", int'(pass_cnt), (kind == 2) ? 0 : ((wraps > 255) ? 255 : wraps));
`endif
    @(negedge clk);
    check("sel_queue_drained", exp_sel_q.size(), 0);
    check("wrap_queue_drained", exp_done_q.size(), 0);
  endtask

  // Start attempts in IDLE that must be ignored.
  task automatic idle_poke(input logic [7:0] m, input logic st);
    @(posedge clk); #1;
    start = 1'b1; stop = st; line_mask = m; dwell = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_valid", int'(valid), 0);
      check("idle_busy", int'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dwell = '0; line_mask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_sel", sel_now(), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_done", int'(done), 0);
`ifdef SCAN_SEQ_PASS_CNT_EN
    check("reset_pass_cnt", int'(pass_cnt), 0);
`endif

    run_scan(8'hFF, 8'd2, 1'b0, 16, 0, 1'b0);
    run_scan(8'b1010_0100, 8'd1, 1'b1, 14, 1, 1'b1);
    run_scan(8'h01, 8'd0, 1'b1, 10, 1, 1'b0);
    run_scan(8'hFF, 8'd1, 1'b0, 4, 1, 1'b0);
    idle_poke(8'hFF, 1'b1);
    idle_poke(8'h00, 1'b0);
    run_scan(8'h5A, 8'd3, 1'b1, 20, 1, 1'b1);
    run_scan(8'h30, 8'd3, 1'b1, 2, 2, 1'b0);
    run_scan(8'h06, 8'd1, 1'b1, 7, 1, 1'b0);
    run_scan(8'h81, 8'd2, 1'b1, 3, 1, 1'b0);

    for (int r = 0; r < 14; r++) begin
      logic [7:0] m, dw;
      logic md;
      int d, p, n, kind;
      m  = 8'($urandom_range(1, 255));
      dw = 8'($urandom_range(0, 4));
      md = 1'($urandom_range(0, 1));
      d  = (dw == 0) ? 1 : int'(dw);
      p  = $countones(m) * d;
      if (md == 1'b0) begin
        n    = int'($urandom_range(1, p));
        kind = (n == p) ? 0 : 1;
      end else begin
        n    = int'($urandom_range(1, 3 * p + 2));
        kind = ($urandom_range(0, 4) == 0) ? 2 : 1;
      end
      run_scan(m, dw, md, n, kind, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("final_sel_queue_empty", exp_sel_q.size(), 0);
    check("final_wrap_queue_empty", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
